// File: rtl/data_memory_if.sv
// Load/store bus between a core's memory stage and the data memory.
interface data_memory_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;

  modport master (
    output Address,
    output DataWr,
    output DMWr,
    output DMCtrl,
    input  DataRd
  );

  modport slave (
    input  Address,
    input  DataWr,
    input  DMWr,
    input  DMCtrl,
    output DataRd
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory with combinational loads and
// byte/halfword/word stores; addresses wrap modulo MEM_BYTES.
module data_memory #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  data_memory_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] idx   [4];
  logic [3:0]    lane_en;
  logic [31:0]   word;

  // Only the low AW address bits select a byte.
  logic unused_addr;
  assign unused_addr = ^bus.Address[31:AW];

  // Lane i always maps to Address+i; the AW-bit add gives wrap-around for free.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i] = bus.Address[AW-1:0] + AW'(i);
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    unique case (bus.DMCtrl)
      3'b000, 3'b100: lane_en = 4'b0001;
      3'b001, 3'b101: lane_en = 4'b0011;
      3'b010:         lane_en = 4'b1111;
      default:        lane_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(MEM_BYTES); j++) begin
        mem_q[j] <= 8'h00;
      end
    end else if (bus.DMWr) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem_q[idx[i]] <= bus.DataWr[8*i +: 8];
        end
      end
    end
  end

  assign word = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};

  always_comb begin
    bus.DataRd = 32'h0000_0000;
    unique case (bus.DMCtrl)
      3'b000:  bus.DataRd = {{24{word[7]}}, word[7:0]};
      3'b001:  bus.DataRd = {{16{word[15]}}, word[15:0]};
      3'b010:  bus.DataRd = word;
      3'b100:  bus.DataRd = {24'h000000, word[7:0]};
      3'b101:  bus.DataRd = {16'h0000, word[15:0]};
      default: bus.DataRd = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed test of data_memory: sized loads/stores, wrap, reserved codes and
// asynchronous reset behaviour.
module tb_data_memory;

  localparam int unsigned MemBytes = 1024;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  data_memory_if bus ();

  data_memory #(
    .MEM_BYTES (MemBytes)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] c, input string tag,
                      input logic [31:0] exp);
    bus.Address = a;
    bus.DMCtrl  = c;
    bus.DMWr    = 1'b0;
    #1;
    check(tag, bus.DataRd, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    bus.Address = a;
    bus.DataWr  = d;
    bus.DMCtrl  = c;
    bus.DMWr    = 1'b1;
    @(posedge clk);
    #1;
    bus.DMWr = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.Address = 32'h0;
    bus.DataWr  = 32'h0;
    bus.DMWr    = 1'b0;
    bus.DMCtrl  = 3'b010;
    #2;
    load(32'h0, 3'b010, "reset_lw", 32'h0000_0000);
    load(32'h0, 3'b000, "reset_lb", 32'h0000_0000);

    // Stores while held in reset must be dropped.
    store(32'h0, 32'hFFFF_FFFF, 3'b010);
    load(32'h0, 3'b010, "reset_wr_ignored", 32'h0000_0000);

    @(negedge clk);
    rst_n = 1'b1;

    store(32'h0, 32'hAABB_CCDD, 3'b010);
    load(32'h0, 3'b010, "sw_lw", 32'hAABB_CCDD);
    load(32'h0, 3'b000, "sw_lb", 32'hFFFF_FFDD);
    load(32'h0, 3'b100, "sw_lbu", 32'h0000_00DD);
    load(32'h0, 3'b001, "sw_lh", 32'hFFFF_CCDD);
    load(32'h2, 3'b101, "sw_lhu_hi", 32'h0000_AABB);

    store(32'h1, 32'h0000_0011, 3'b000);
    load(32'h0, 3'b010, "sb_merge", 32'hAABB_11DD);
    store(32'h0, 32'hDEAD_BEEF, 3'b111);
    load(32'h0, 3'b010, "ctrl111_nowrite", 32'hAABB_11DD);
    load(32'h0, 3'b111, "ctrl111_rd", 32'h0000_0000);
    load(32'h0, 3'b011, "ctrl011_rd", 32'h0000_0000);
    load(32'h0, 3'b110, "ctrl110_rd", 32'h0000_0000);
    store(32'h0, 32'hDEAD_BEEF, 3'b011);
    store(32'h0, 32'hDEAD_BEEF, 3'b110);
    load(32'h0, 3'b010, "ctrl011_110_nowrite", 32'hAABB_11DD);

    store(32'h4, 32'h0000_00EE, 3'b000);
    load(32'h4, 3'b000, "sb_lb", 32'hFFFF_FFEE);
    load(32'h4, 3'b100, "sb_lbu", 32'h0000_00EE);
    load(32'h4, 3'b010, "sb_lw", 32'h0000_00EE);

    store(32'h8, 32'h1234_FACE, 3'b001);
    load(32'h8, 3'b001, "sh_lh", 32'hFFFF_FACE);
    load(32'h8, 3'b101, "sh_lhu", 32'h0000_FACE);
    load(32'h8, 3'b010, "sh_lw", 32'h0000_FACE);
    load(32'h9, 3'b000, "sh_lb_hi", 32'hFFFF_FFFA);

    load(32'h0000_0400, 3'b010, "alias_upper", 32'hAABB_11DD);
    load(32'hFFFF_FC04, 3'b100, "alias_high_bits", 32'h0000_00EE);

    // Read during write: old data before the edge, new data after.
    bus.Address = 32'hC;
    bus.DataWr  = 32'h0102_0304;
    bus.DMCtrl  = 3'b010;
    bus.DMWr    = 1'b1;
    #1;
    check("rdw_pre_edge", bus.DataRd, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rdw_post_edge", bus.DataRd, 32'h0102_0304);
    bus.DMWr = 1'b0;

    store(MemBytes - 2, 32'h1234_5678, 3'b010);
    load(MemBytes - 2, 3'b010, "wrap_lw", 32'h1234_5678);
    load(32'h0, 3'b101, "wrap_lhu0", 32'h0000_1234);
    load(32'h0, 3'b010, "wrap_lw0", 32'hAABB_1234);

    // Asynchronous reset between edges with a store pending.
    bus.Address = 32'h10;
    bus.DataWr  = 32'hCAFE_F00D;
    bus.DMCtrl  = 3'b010;
    bus.DMWr    = 1'b1;
    #3;
    rst_n = 1'b0;
    bus.Address = 32'h0;
    #1;
    check("async_rst_lw0", bus.DataRd, 32'h0000_0000);
    bus.Address = MemBytes - 2;
    #1;
    check("async_rst_wrap", bus.DataRd, 32'h0000_0000);
    bus.Address = 32'h10;
    @(posedge clk);
    #1;
    check("rst_pending_aborted", bus.DataRd, 32'h0000_0000);
    bus.DMWr = 1'b0;
    load(32'h8, 3'b001, "rst_lh", 32'h0000_0000);

    @(negedge clk);
    rst_n = 1'b1;
    store(32'h20, 32'h0000_005A, 3'b100);
    load(32'h20, 3'b100, "first_write_after_rst", 32'h0000_005A);
    load(32'h10, 3'b010, "post_rst_lw10", 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter MEM_BYTES, default 1024, sets byte-addressable storage capacity; power of two, minimum 8.
REQ-002 clk  input  1  sole clock; all writes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Address  input  32  byte address of access.
REQ-005 DataWr  input  32  store data; low byte/halfword used for narrow stores.
REQ-006 DMWr  input  1  write enable; 1 = store, 0 = load.
REQ-007 DMCtrl  input  3  access size/sign select.
REQ-008 DataRd  output  32  load data, combinational.

Function
REQ-009 Storage SHALL be MEM_BYTES bytes, little-endian: byte at Address holds bits [7:0], Address+1 bits [15:8], and so on.
REQ-010 Effective byte index SHALL be Address modulo MEM_BYTES; upper address bits ignored.
REQ-011 Multi-byte accesses crossing the top of memory SHALL wrap to byte 0; no alignment checks, no exceptions.
REQ-012 DMCtrl encoding: 000 byte signed, 001 halfword signed, 010 word, 100 byte unsigned, 101 halfword unsigned.
REQ-013 Store size from DMCtrl: 000/100 byte (DataWr[7:0]), 001/101 halfword (DataWr[15:0]), 010 word (DataWr[31:0]).
REQ-014 Store SHALL commit on rising clk when DMWr=1 and rst_n=1; only addressed bytes change.
REQ-015 DMCtrl 011, 110, 111 with DMWr=1: no bytes modified.
REQ-016 DataRd SHALL be combinational from Address, DMCtrl and current storage, regardless of DMWr; zero latency.
REQ-017 Load 000: sign-extend byte; 100: zero-extend byte.
REQ-018 Load 001: sign-extend halfword; 101: zero-extend halfword.
REQ-019 Load 010: full 32-bit word.
REQ-020 DMCtrl 011, 110, 111: DataRd = 0.
REQ-021 Read during a write cycle SHALL show pre-edge contents until the edge, then new contents (no internal forwarding).

Reset
REQ-022 rst_n=0 SHALL immediately, asynchronously clear every storage byte to 0x00.
REQ-023 While rst_n=0, writes ignored; DataRd reflects zeroed storage (0 for every valid DMCtrl).
REQ-024 Reset release SHALL be synchronous-safe: first write accepted on first rising clk with rst_n=1.
REQ-025 Reset mid-operation SHALL abort pending store; no partial bytes survive.

Verification
REQ-026 Reset, then DMCtrl=010, Address=0x0 -> DataRd=0x00000000.
REQ-027 SW 0xAABBCCDD at 0x0, one clk, DMWr=0, DMCtrl=010 -> DataRd=0xAABBCCDD; DMCtrl=000 -> 0xFFFFFFDD.
REQ-028 SB 0x000000EE at 0x4, then LB -> 0xFFFFFFEE; LBU (100) -> 0x000000EE; LW at 0x4 -> 0x000000EE.
REQ-029 SH 0x0000FACE at 0x8, then LH -> 0xFFFFFACE; LHU (101) -> 0x0000FACE.
REQ-030 After REQ-027, SB 0x11 at 0x1 -> LW 0x0 = 0xAABB11DD; SW with DMCtrl=111 at 0x0 -> word unchanged, DataRd for 111 = 0.
REQ-031 SW 0x12345678 at MEM_BYTES-2 -> LW same address = 0x12345678, LHU at 0x0 = 0x00001234; assert rst_n mid-sequence -> LW any address = 0.
